// File: rtl/fhg_tx_pkt_arbiter.sv
// rtl/fhg_tx_pkt_arbiter.sv - packet-granular round-robin arbiter feeding one 400G TX path
// Optional inter-packet gap state enabled by defining FHG_ARB_IFG_EN.
module fhg_tx_pkt_arbiter #(
  parameter int N_PORTS       = 4,
  parameter int DATA_WIDTH    = 1024,
  parameter int KEEP_WIDTH    = 128,
  parameter int MAX_PKT_BEATS = 64,
  parameter int IFG_CYC       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [N_PORTS*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [N_PORTS-1:0]            s_tvalid,
  input  logic [N_PORTS-1:0]            s_tlast,
  input  logic [N_PORTS-1:0]            s_tuser,
  output logic [N_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  output logic [KEEP_WIDTH-1:0]         m_tkeep,
  output logic                          m_tvalid,
  output logic                          m_tlast,
  output logic                          m_tuser,
  input  logic                          m_tready,
  input  logic                          tx_af,
  output logic [$clog2(N_PORTS)-1:0]    grant_id,
  output logic                          busy,
  output logic                          trunc_err
);

  localparam int GW = $clog2(N_PORTS);
  localparam int CW = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DRAIN = 2'd2
`ifdef FHG_ARB_IFG_EN
    , ST_GAP = 2'd3
`endif
  } state_t;

  // State entered once a packet has fully left (tlast or end of drain).
  localparam state_t ST_POST =
`ifdef FHG_ARB_IFG_EN
    ST_GAP;
`else
    ST_IDLE;
`endif

  state_t         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  rr_q, rr_d;
  logic [CW-1:0]  beat_q, beat_d;
  logic [GW-1:0]  arb_pick;
  logic           arb_found;
  logic [GW-1:0]  grant_inc;
  logic           sel_valid, sel_last, sel_user;
  logic           at_max, xfer, trunc_beat;

`ifdef FHG_ARB_IFG_EN
  localparam int GPW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
  logic [GPW-1:0] gap_q, gap_d;
`else
  logic           unused_ifg;
  assign unused_ifg = (IFG_CYC != 0);
`endif

  assign sel_valid  = s_tvalid[grant_q];
  assign sel_last   = s_tlast[grant_q];
  assign sel_user   = s_tuser[grant_q];
  assign at_max     = (beat_q == CW'(MAX_PKT_BEATS - 1));
  assign xfer       = (state_q == ST_PASS) && sel_valid && m_tready;
  assign trunc_beat = xfer && at_max && !sel_last;
  assign grant_inc  = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
  assign grant_id   = grant_q;

  // First valid port at or after rr_q, wrapping modulo N_PORTS.
  always_comb begin : arb_search
    logic [GW:0] idx;
    arb_found = 1'b0;
    arb_pick  = '0;
    idx       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = {1'b0, rr_q} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_PORTS)) idx = idx - (GW+1)'(N_PORTS);
      if (!arb_found && s_tvalid[idx[GW-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
`ifdef FHG_ARB_IFG_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
`ifdef FHG_ARB_IFG_EN
      gap_q   <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
`ifdef FHG_ARB_IFG_EN
    gap_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!tx_af && arb_found) begin
          grant_d = arb_pick;
          beat_d  = '0;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (xfer) begin
          if (sel_last) begin
            rr_d    = grant_inc;
            beat_d  = '0;
            state_d = ST_POST;
          end else if (at_max) begin
            rr_d    = grant_inc;
            beat_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (sel_valid && sel_last) state_d = ST_POST;
      end
`ifdef FHG_ARB_IFG_EN
      ST_GAP: begin
        if (gap_q == GPW'(IFG_CYC - 1)) state_d = ST_IDLE;
        else                             gap_d   = gap_q + 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_tready  = '0;
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tuser   = 1'b0;
    busy      = 1'b0;
    trunc_err = 1'b0;
    case (state_q)
      ST_PASS: begin
        busy               = 1'b1;
        s_tready[grant_q]  = m_tready;
        m_tdata            = s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        m_tkeep            = s_tkeep[int'(grant_q)*KEEP_WIDTH +: KEEP_WIDTH];
        m_tvalid           = sel_valid;
        m_tlast            = sel_last | at_max;
        m_tuser            = sel_user | (at_max & ~sel_last);
        trunc_err          = trunc_beat;
      end
      ST_DRAIN: begin
        busy               = 1'b1;
        s_tready[grant_q]  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fhg_tx_pkt_arbiter.sv
// tb/tb_fhg_tx_pkt_arbiter.sv - directed self-checking bench for fhg_tx_pkt_arbiter
module tb_fhg_tx_pkt_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 1024;
  localparam int KW   = 128;
  localparam int MAXB = 64;
  localparam int IFG  = 2;
`ifdef FHG_ARB_IFG_EN
  localparam int PKT_SPACING = 2 + IFG;
`else
  localparam int PKT_SPACING = 2;
`endif

  logic             clk;
  logic             rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tvalid, s_tlast, s_tuser, s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid, m_tlast, m_tuser, m_tready, tx_af;
  logic [1:0]       grant_id;
  logic             busy, trunc_err;

  fhg_tx_pkt_arbiter #(
    .N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_PKT_BEATS(MAXB), .IFG_CYC(IFG)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready), .tx_af(tx_af),
    .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int port;
    int beats;
    bit last_user;
    bit mid_user;
    bit ok;
  } pkt_t;

  int        src_left[NP], src_len[NP], src_beat[NP], src_pk[NP];
  logic [NP-1:0] xfer_s;
  bit        tog_rdy;
  int        cyc;
  pkt_t      pkts[$];
  int        first_cyc[$], last_cyc[$];
  int        cur_beats, cur_port, cur_pk;
  bit        cur_ok, cur_mid;
  int        trunc_cnt, trunc_beat, rdy_err;
  int        n_vec, n_miss;

  function automatic logic [DW-1:0] word_of(int p, int pk, int b);
    logic [31:0] w;
    w = {8'hA5, 8'(pk), 8'(p), 8'(b)};
    return {(DW/32){w}};
  endfunction

  function automatic logic [KW-1:0] keep_of(int p);
    logic [KW-1:0] k;
    k = '1;
    return k >> p;
  endfunction

  task automatic drive_sources();
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p]           = (src_left[p] > 0);
      s_tlast[p]            = (src_beat[p] == src_len[p] - 1);
      s_tuser[p]            = 1'b0;
      s_tdata[p*DW +: DW]   = word_of(p, src_pk[p], src_beat[p]);
      s_tkeep[p*KW +: KW]   = keep_of(p);
    end
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      src_left[p] = 0; src_len[p] = 1; src_beat[p] = 0; src_pk[p] = 0;
    end
    drive_sources();
  endtask

  task automatic clear_capture();
    pkts.delete(); first_cyc.delete(); last_cyc.delete();
    cur_beats = 0; trunc_cnt = 0; trunc_beat = 0;
  endtask

  task automatic load(int p, int n, int len);
    src_left[p] = n; src_len[p] = len; src_beat[p] = 0;
    drive_sources();
  endtask

  // One clock: observe at negedge, then advance the source models after posedge.
  task automatic tick();
    int p, pk, b;
    @(negedge clk);
    xfer_s = s_tvalid & s_tready;
    for (int q = 0; q < NP; q++)
      if (q != int'(grant_id) && s_tready[q]) rdy_err++;
    if (!busy && s_tready != '0) rdy_err++;
    if (m_tvalid && s_tready[grant_id] !== m_tready) rdy_err++;
    if (m_tvalid && m_tready) begin
      p  = int'(m_tdata[15:8]);
      pk = int'(m_tdata[23:16]);
      b  = int'(m_tdata[7:0]);
      if (cur_beats == 0) begin
        cur_port = p; cur_pk = pk; cur_ok = 1'b1; cur_mid = 1'b0;
        first_cyc.push_back(cyc);
      end
      if (p != cur_port || pk != cur_pk || b != cur_beats || m_tdata !== word_of(p, pk, b) ||
          m_tkeep !== keep_of(p) || int'(grant_id) != p)
        cur_ok = 1'b0;
      if (trunc_err) begin trunc_cnt++; trunc_beat = cur_beats + 1; end
      if (m_tlast) begin
        pkts.push_back('{cur_port, cur_beats + 1, m_tuser, cur_mid, cur_ok});
        last_cyc.push_back(cyc);
        cur_beats = 0;
      end else begin
        cur_mid = cur_mid | m_tuser;
        cur_beats++;
      end
    end else if (trunc_err) begin
      trunc_cnt++; trunc_beat = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int q = 0; q < NP; q++) begin
      if (xfer_s[q]) begin
        if (src_beat[q] == src_len[q] - 1) begin
          src_beat[q] = 0; src_pk[q]++; src_left[q]--;
        end else begin
          src_beat[q]++;
        end
      end
    end
    if (tog_rdy) m_tready = ~m_tready;
    drive_sources();
  endtask

  task automatic run_idle(int budget, string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      done = (src_left[0] + src_left[1] + src_left[2] + src_left[3] == 0) && !busy && cur_beats == 0;
    end
    n_vec++;
    if (!done) begin
      n_miss++;
      $display("FAIL %s_timeout: not idle after %0d cycles, required idle", name, budget);
    end
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load(0, 1, 4);
    repeat (2) tick();
    n_vec++; if (s_tready !== '0) begin n_miss++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
    n_vec++; if (m_tvalid !== 1'b0) begin n_miss++; $display("FAIL rst_m_tvalid: got %b want 0", m_tvalid); end
    n_vec++; if (m_tlast !== 1'b0) begin n_miss++; $display("FAIL rst_m_tlast: got %b want 0", m_tlast); end
    n_vec++; if (m_tuser !== 1'b0) begin n_miss++; $display("FAIL rst_m_tuser: got %b want 0", m_tuser); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (trunc_err !== 1'b0) begin n_miss++; $display("FAIL rst_trunc_err: got %b want 0", trunc_err); end
    n_vec++; if (grant_id !== 2'd0) begin n_miss++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    n_vec++; if (m_tdata !== '0) begin n_miss++; $display("FAIL rst_m_tdata: got nonzero want 0"); end
    clear_sources();
    rst = 1'b0;
    tick();
    clear_capture();
  endtask

  task automatic test_two_ports();
    int exp_port[4] = '{0, 2, 0, 2};
    clear_capture();
    load(0, 2, MAXB);
    load(2, 2, MAXB);
    run_idle(600, "two_ports");
    n_vec++; if (pkts.size() != 4) begin n_miss++; $display("FAIL two_ports_count: got %0d want 4", pkts.size()); end
    for (int i = 0; i < 4 && i < pkts.size(); i++) begin
      n_vec++; if (pkts[i].port != exp_port[i]) begin n_miss++; $display("FAIL two_ports_grant%0d: got %0d want %0d", i, pkts[i].port, exp_port[i]); end
      n_vec++; if (pkts[i].beats != MAXB) begin n_miss++; $display("FAIL two_ports_len%0d: got %0d want %0d", i, pkts[i].beats, MAXB); end
      n_vec++; if (!pkts[i].ok || pkts[i].last_user || pkts[i].mid_user) begin n_miss++; $display("FAIL two_ports_data%0d: ok=%0d user=%0d/%0d want 1/0/0", i, pkts[i].ok, pkts[i].last_user, pkts[i].mid_user); end
    end
    n_vec++; if (trunc_cnt != 0) begin n_miss++; $display("FAIL two_ports_trunc: got %0d pulses want 0", trunc_cnt); end
  endtask

  task automatic test_rr_all();
    int exp_port[4] = '{1, 2, 3, 0};
    clear_capture();
    load(0, 1, 3);
    run_idle(100, "rr_prime");
    clear_capture();
    for (int p = 0; p < NP; p++) load(p, 1, 3);
    run_idle(200, "rr_all");
    n_vec++; if (pkts.size() != 4) begin n_miss++; $display("FAIL rr_count: got %0d want 4", pkts.size()); end
    for (int i = 0; i < 4 && i < pkts.size(); i++) begin
      n_vec++; if (pkts[i].port != exp_port[i] || !pkts[i].ok) begin n_miss++; $display("FAIL rr_grant%0d: got port %0d ok %0d want port %0d ok 1", i, pkts[i].port, pkts[i].ok, exp_port[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int exp_port[4] = '{1, 0, 1, 0};
    clear_capture();
    load(0, 2, 3);
    load(1, 2, 3);
    run_idle(200, "b2b");
    n_vec++; if (pkts.size() != 4 || first_cyc.size() != 4) begin n_miss++; $display("FAIL b2b_count: got %0d want 4", pkts.size()); end
    for (int i = 0; i < 4 && i < pkts.size(); i++) begin
      n_vec++; if (pkts[i].port != exp_port[i] || pkts[i].beats != 3) begin n_miss++; $display("FAIL b2b_pkt%0d: got port %0d len %0d want port %0d len 3", i, pkts[i].port, pkts[i].beats, exp_port[i]); end
    end
    for (int i = 0; i < 3 && i + 1 < first_cyc.size(); i++) begin
      n_vec++; if (first_cyc[i+1] - last_cyc[i] != PKT_SPACING) begin n_miss++; $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", i, first_cyc[i+1] - last_cyc[i], PKT_SPACING); end
    end
  endtask

  task automatic test_tx_af();
    int waited;
    clear_capture();
    tx_af = 1'b1;
    load(1, 1, 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++; if ({busy, s_tready} !== 5'b0) begin n_miss++; $display("FAIL af_hold%0d: busy=%b s_tready=%b want 0/0000", i, busy, s_tready); end
    end
    tx_af = 1'b0;
    repeat (2) tick();
    n_vec++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_miss++; $display("FAIL af_release: grant=%0d busy=%b want 1/1", grant_id, busy); end
    run_idle(100, "af_release");
    n_vec++; if (pkts.size() != 1 || pkts[0].port != 1 || pkts[0].beats != 5 || !pkts[0].ok) begin n_miss++; $display("FAIL af_pkt: count %0d want 1 port1 len5 intact", pkts.size()); end
    clear_capture();
    load(2, 1, 12);
    waited = 0;
    while (!busy && waited < 20) begin tick(); waited++; end
    repeat (3) tick();
    tx_af = 1'b1;
    run_idle(100, "af_mid");
    tx_af = 1'b0;
    n_vec++; if (pkts.size() != 1 || pkts[0].beats != 12 || !pkts[0].ok) begin n_miss++; $display("FAIL af_mid_pkt: count %0d want 1 packet of 12 intact", pkts.size()); end
    n_vec++; if (first_cyc.size() != 1 || last_cyc[0] - first_cyc[0] != 11) begin n_miss++; $display("FAIL af_mid_stall: span %0d want 11", (first_cyc.size() == 1) ? last_cyc[0] - first_cyc[0] : -1); end
  endtask

  task automatic test_truncation();
    clear_capture();
    load(3, 1, 70);
    run_idle(300, "trunc");
    n_vec++; if (pkts.size() != 1) begin n_miss++; $display("FAIL trunc_count: got %0d want 1", pkts.size()); end
    if (pkts.size() > 0) begin
      n_vec++; if (pkts[0].port != 3 || pkts[0].beats != MAXB) begin n_miss++; $display("FAIL trunc_len: got port %0d len %0d want 3/%0d", pkts[0].port, pkts[0].beats, MAXB); end
      n_vec++; if (pkts[0].last_user !== 1'b1 || pkts[0].mid_user !== 1'b0) begin n_miss++; $display("FAIL trunc_tuser: got last %0d mid %0d want 1/0", pkts[0].last_user, pkts[0].mid_user); end
      n_vec++; if (!pkts[0].ok) begin n_miss++; $display("FAIL trunc_data: got corrupted want intact"); end
    end
    n_vec++; if (trunc_cnt != 1 || trunc_beat != MAXB) begin n_miss++; $display("FAIL trunc_pulse: got %0d pulses at beat %0d want 1 at %0d", trunc_cnt, trunc_beat, MAXB); end
    n_vec++; if (src_left[3] != 0) begin n_miss++; $display("FAIL trunc_drain: got %0d packets left want 0", src_left[3]); end
  endtask

  task automatic test_backpressure();
    clear_capture();
    tog_rdy = 1'b1;
    load(1, 1, 20);
    run_idle(200, "bp");
    tog_rdy = 1'b0;
    m_tready = 1'b1;
    n_vec++; if (pkts.size() != 1 || pkts[0].port != 1 || pkts[0].beats != 20 || !pkts[0].ok) begin n_miss++; $display("FAIL bp_pkt: count %0d want 1 port1 len20 intact", pkts.size()); end
    n_vec++; if (rdy_err != 0) begin n_miss++; $display("FAIL bp_tready: got %0d ready violations want 0", rdy_err); end
  endtask

  task automatic test_reset_mid();
    int waited;
    clear_capture();
    load(0, 1, 50);
    waited = 0;
    while (cur_beats != 30 && waited < 200) begin tick(); waited++; end
    n_vec++; if (cur_beats != 30) begin n_miss++; $display("FAIL rmid_reach: got %0d beats want 30", cur_beats); end
    rst = 1'b1;
    tick();
    n_vec++; if ({s_tready, m_tvalid, m_tlast, m_tuser, busy, trunc_err} !== 9'b0) begin n_miss++; $display("FAIL rmid_outputs: s_tready=%b m_tvalid=%b busy=%b want 0", s_tready, m_tvalid, busy); end
    n_vec++; if (grant_id !== 2'd0) begin n_miss++; $display("FAIL rmid_grant: got %0d want 0", grant_id); end
    rst = 1'b0;
    clear_sources();
    tick();
    clear_capture();
    load(2, 1, 4);
    load(0, 1, 4);
    run_idle(100, "rmid");
    n_vec++; if (pkts.size() != 2 || pkts[0].port != 0 || pkts[1].port != 2) begin n_miss++; $display("FAIL rmid_rr: first port %0d count %0d want 0 then 2", (pkts.size() > 0) ? pkts[0].port : -1, pkts.size()); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_miss = 0; cyc = 0; rdy_err = 0; tog_rdy = 1'b0;
    rst = 1'b1; tx_af = 1'b0; m_tready = 1'b1;
    clear_sources();
    clear_capture();
    test_reset();
    test_two_ports();
    test_rr_all();
    test_back_to_back();
    test_tx_af();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
